instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch front-end: owns the PC, drives the address of the
//  combinational-read 64x32 instruction ROM, and queues {pc, instr} pairs in
//  a 2-entry buffer toward decode with valid/ready backpressure.
//  It handles branch redirect with flush, a halt request, and counts fetches.
//  It sits between the instruction ROM and the decode stage of the RISC-V core.
// PARAMETERS
//  ADDR_W    6   byte-address width; matches the ROM index
//  DATA_W    32  instruction width
//  RESET_PC  0   PC loaded on reset; must be a multiple of 4
//  PC_STEP   4   PC increment per fetch
//  CNT_W     16  width of the fetch counter
// PORTS
//  clk            in   1       clock; all state changes on the rising edge
//  rst            in   1       synchronous reset, active-high
//  endereco       out  ADDR_W  ROM address; always equals pc_q
//  saida          in   DATA_W  ROM read data, valid in the same cycle
//  instr_out      out  DATA_W  instruction at the buffer head
//  pc_out         out  ADDR_W  address of instr_out
//  valid_out      out  1       buffer head is valid
//  ready_in       in   1       decode accepts the head this cycle
//  redirect_en    in   1       branch/jump taken; flush and restart
//  redirect_pc    in   ADDR_W  new PC; bits [1:0] are forced to 0
//  halt_req       in   1       stop fetching (1-cycle pulse is enough)
//  halted         out  1       FSM is in HALTED
//  fetch_cnt      out  CNT_W   number of pushes since reset; saturates
// BEHAVIOUR
//  Reset values:
//   - pc_q=RESET_PC, so endereco=RESET_PC.
//   - Buffer count=0, valid_out=0, instr_out=0, pc_out=0.
//   - halted=0, fetch_cnt=0, state=IDLE.
//   - rst takes priority over every other input, including mid-operation.
//  FSM:
//   - IDLE -> FETCH unconditionally. This gives one bubble after reset.
//   - FETCH -> HALTED on halt_req, when redirect_en is low.
//   - HALTED -> FETCH only on redirect_en. Otherwise HALTED holds until rst.
//  Push:
//   - Happens in FETCH when redirect_en=0, halt_req=0, and either
//     count<2 or (count==2 and a pop occurs this cycle).
//   - Writes {pc_q, saida} at the tail.
//   - pc_q += PC_STEP modulo 2^ADDR_W, so 60 wraps silently to 0.
//   - fetch_cnt increments and saturates at all-ones.
//  Pop: valid_out && ready_in. The head advances. Push and pop in the same
//   cycle keep count unchanged.
//  Full buffer with no pop: pc_q and endereco hold, no push. No entry is ever
//   dropped or duplicated.
//  Output timing: instr_out, pc_out and valid_out come from registers.
//   Latency from pc_q==A (empty buffer) to instr_out of A is 1 cycle.
//   Throughput is 1 instr/cycle while ready_in=1.
//  Redirect (redirect_en=1, any state except during rst):
//   - Next cycle: buffer flushed (count=0, valid_out=0), pc_q={redirect_pc[ADDR_W-1:2],2'b00}.
//   - No push that cycle. State becomes FETCH.
//   - A same-cycle pop is still counted as accepted.
//   - The first target instruction appears 2 cycles after the redirect edge.
//  Redirect together with halt_req: redirect wins.
//  HALTED: no pushes. The buffer drains normally through ready_in.
// STRUCTURE
//  Shared package riscv_pkg:
//   - ADDR_W, DATA_W, PC_STEP.
//   - fetch-state typedef {IDLE, FETCH, HALTED}.
//  Sub-module fetch_fifo:
//   - 2-entry synchronous FIFO, width ADDR_W+DATA_W.
//   - Ports: push, pop, flush, full, empty, head.
//   - Flush has priority over push.
//  Top level: PC register, FSM, push/pop logic, fetch counter.
// TESTING  (ROM preloaded: [0]=32'h00102083, [4]=32'h00202103)
//  1. Release rst, ready_in=1 -> valid_out low 2 cycles; then pc_out/instr_out
//     0/00102083, 4/00202103, 8/... on consecutive cycles.
//  2. ready_in=0 for 5 cycles after the first valid -> endereco holds at 8 and
//     the head stays pc 0. After release, pc_out goes 0,4,8 with no gap or duplicate.
//  3. redirect_en with redirect_pc=36 while the buffer is full -> valid_out=0
//     the next cycle, then pc_out=36. No stale entry appears.
//  4. redirect_pc=6'h27 -> fetch resumes at 36. Redirect to 60 with ready_in=1
//     -> pc_out 60 then 0 (wrap).
//  5. halt_req pulse -> halted=1 and fetch_cnt freezes. The buffer drains to
//     valid_out=0. redirect_en to 12 -> halted=0 and pc_out=12 is delivered.
//  6. rst asserted while valid_out=1 and the buffer is full -> next cycle
//     valid_out=0, endereco=0, fetch_cnt=0, state IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front-end.
// Contents:
//   ADDR_W, DATA_W, PC_STEP, CNT_W  bus widths and PC increment
//   fetch_state_t                   fetch FSM states {IDLE, FETCH, HALTED}
//   fetch_entry_t                   {pc, instr} pair held in the fetch buffer
//   word_align()                    clears the two byte-offset bits of an address
package riscv_pkg;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;
  localparam int PC_STEP = 4;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned, so the low two address bits are dropped.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus between the fetch unit and its environment (instruction ROM,
// decode stage and branch/halt control).
// Signals:
//   endereco    ROM address (fetch unit -> ROM)
//   saida       ROM read data, combinational (ROM -> fetch unit)
//   instr_out   instruction at the buffer head (fetch unit -> decode)
//   pc_out      address of instr_out
//   valid_out   buffer head valid
//   ready_in    decode accepts the head this cycle
//   redirect_en branch/jump taken: flush and restart at redirect_pc
//   redirect_pc new PC (low two bits ignored)
//   halt_req    stop fetching
//   halted      fetch FSM is halted
//   fetch_cnt   saturating count of buffer pushes since reset
// Modports: master = fetch unit side, slave = environment side.
interface instr_fetch_unit_if;
  import riscv_pkg::*;

  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] saida;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] pc_out;
  logic              valid_out;
  logic              ready_in;
  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt_req;
  logic              halted;
  logic [CNT_W-1:0]  fetch_cnt;

  modport master (
    output endereco, instr_out, pc_out, valid_out, halted, fetch_cnt,
    input  saida, ready_in, redirect_en, redirect_pc, halt_req
  );

  modport slave (
    input  endereco, instr_out, pc_out, valid_out, halted, fetch_cnt,
    output saida, ready_in, redirect_en, redirect_pc, halt_req
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO for fetched {pc, instr} pairs.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   push/din  write din at the tail (ignored when full without a pop)
//   pop       discard the head (ignored when empty)
//   flush     empty the FIFO; wins over push and pop
//   full      two entries held
//   empty     no entry held
//   head      oldest entry, taken straight from a register
// Entries shift toward slot 0 so the head is always entry_reg[0]; occupancy
// is a thermometer code (00/01/11) so full and empty are plain flops.
module fetch_fifo #(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0] entry_reg [2];
  logic [1:0]   valid_reg;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && valid_reg[0];
  assign do_push = push && (!valid_reg[1] || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= 2'b00;
      entry_reg[0] <= '0;
      entry_reg[1] <= '0;
    end else if (flush) begin
      valid_reg <= 2'b00;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (!valid_reg[0]) entry_reg[0] <= din;
          else               entry_reg[1] <= din;
          valid_reg <= {valid_reg[0], 1'b1};
        end
        2'b01: begin
          entry_reg[0] <= entry_reg[1];
          valid_reg    <= {1'b0, valid_reg[1]};
        end
        2'b11: begin
          // Occupancy is unchanged; the new entry lands behind whatever remains.
          if (valid_reg[1]) begin
            entry_reg[0] <= entry_reg[1];
            entry_reg[1] <= din;
          end else begin
            entry_reg[0] <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign full  = valid_reg[1];
  assign empty = !valid_reg[0];
  assign head  = entry_reg[0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end. Owns the PC, addresses the combinational
// instruction ROM and queues {pc, instr} pairs toward decode through a
// 2-entry buffer with valid/ready backpressure. Handles branch redirect
// (flush + restart), halt requests, and counts pushes.
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  synchronous reset, active-high, overrides every other input
//   bus  instr_fetch_unit_if.master (ROM address/data, decode handshake,
//        redirect/halt control, halted flag, fetch counter)
// Parameter:
//   RESET_PC  PC loaded on reset, multiple of 4
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_unit_if.master  bus
);

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic              halted_reg;
  logic [CNT_W-1:0]  fetch_cnt_reg;

  logic              fifo_full;
  logic              fifo_empty;
  fetch_entry_t      fifo_head;
  fetch_entry_t      fifo_din;
  logic              pop;
  logic              push;

  assign pop = !fifo_empty && bus.ready_in;

  // A full buffer may still accept a push when its head leaves this cycle.
  assign push = (state_reg == FETCH) && !bus.redirect_en && !bus.halt_req &&
                (!fifo_full || pop);

  assign fifo_din = '{pc: pc_reg, instr: bus.saida};

  fetch_fifo #(
    .W($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_en),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      halted_reg    <= 1'b0;
      fetch_cnt_reg <= '0;
    end else begin
      if (bus.redirect_en) begin
        // Redirect wins over halt and leaves any state, including HALTED.
        state_reg  <= FETCH;
        pc_reg     <= word_align(bus.redirect_pc);
        halted_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: state_reg <= FETCH;
          FETCH: begin
            if (bus.halt_req) begin
              state_reg  <= HALTED;
              halted_reg <= 1'b1;
            end else if (push) begin
              pc_reg <= pc_reg + ADDR_W'(PC_STEP);
            end
          end
          HALTED: ;
          default: state_reg <= IDLE;
        endcase
      end

      if (push && (fetch_cnt_reg != '1)) begin
        fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.endereco  = pc_reg;
  assign bus.instr_out = fifo_head.instr;
  assign bus.pc_out    = fifo_head.pc;
  assign bus.valid_out = !fifo_empty;
  assign bus.halted    = halted_reg;
  assign bus.fetch_cnt = fetch_cnt_reg;

endmodule
